ad9361_multi_gate: RTL and testbench
====================================

Name: ad9361_multi_gate

Overview:
- Parametrised successor to the four-channel AD9361 sample squelch filter. Gates N independent IQ channels on a per-channel moving-average magnitude.
- Adds hysteresis: runtime on/off thresholds.
- Adds a pre-trigger history of valid samples and a post-trigger hang time.
- Adds a ganged mode, a start-of-burst marker and a bypass input.
- Sits between the AD9361 receive interface and the downstream capture/DMA path, so only bursts containing signal are forwarded.

Parameters:
- NUM_CHANS, 4, number of IQ channels.
- DATA_WIDTH, 12, width of each I and Q sample (two's complement).
- ABS_WIDTH, 16, magnitude/average/threshold width; must be >= DATA_WIDTH+1.
- AVG_LENGTH, 16, boxcar length in valid samples; power of 2, >= 2.
- PRE_SAMPS, 8, pre-trigger depth in valid samples; 0 allowed.
- POST_SAMPS, 8, hang length in valid samples after the close condition; 0 allowed.
- GANG, 0, 1 = the gate of every channel is the OR of all channel gates.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- bypass  in  1  1 = valid_out mirrors valid_in (registered); gate logic keeps running
- thresh_on  in  ABS_WIDTH  open threshold (strict >)
- thresh_off  in  ABS_WIDTH  close threshold (strict <)
- valid_in  in  NUM_CHANS  per-channel sample strobe
- data_i_in  in  NUM_CHANS*DATA_WIDTH  I samples; channel n at bits [n*DATA_WIDTH +: DATA_WIDTH]
- data_q_in  in  NUM_CHANS*DATA_WIDTH  Q samples, same packing
- valid_out  out  NUM_CHANS  gated strobe
- data_i_out  out  NUM_CHANS*DATA_WIDTH  delayed I samples
- data_q_out  out  NUM_CHANS*DATA_WIDTH  delayed Q samples
- sof_out  out  NUM_CHANS  high with the first valid_out of each burst
- gate_open  out  NUM_CHANS  1 while the channel FSM is not IDLE

Behaviour:
- One clock; all state updates only on clk rising edge. Per-channel logic advances only on cycles where valid_in[n]=1; otherwise it holds.
- Reset (rst=1, any time, including mid-burst):
  - next cycle valid_out, sof_out, gate_open, data_*_out = 0.
  - Delay lines, magnitude history, boxcar sum and hang counters are cleared; FSMs go to IDLE.
- Magnitude: mag = |I|+|Q|, zero-extended to ABS_WIDTH. Max value 2^DATA_WIDTH, so no saturation is needed.
- Boxcar:
  - Holds the last AVG_LENGTH mags; sum is ABS_WIDTH+log2(AVG_LENGTH) bits.
  - On each valid: sum <= sum + mag - oldest.
  - avg = sum >> log2(AVG_LENGTH), registered. The decision at valid sample k uses the average of samples k-AVG_LENGTH..k-1 (cleared history counts as 0).
- Delay: per-channel I/Q shift register of PRE_SAMPS stages, shifted on valid. The sample forwarded for input k is sample k-PRE_SAMPS; PRE_SAMPS=0 forwards k itself.
- FSM per channel, evaluated on valid:
  - IDLE: avg > thresh_on -> OPEN; otherwise stay.
  - OPEN: avg < thresh_off -> HANG, cnt <= POST_SAMPS; otherwise stay.
  - HANG:
    - avg > thresh_on -> OPEN (takes priority).
    - else cnt > 0 -> stay, cnt--.
    - else cnt = 0 -> IDLE.
  - thresh_off > thresh_on is legal; the rules apply as written with no special casing.
- Gate for sample k: open_k = (next state != IDLE). With GANG=1, open_k(n) = OR over all channels of their own open_k, using each channel's current-cycle next state.
- Outputs, registered, 1-cycle latency from valid_in:
  - valid_out[n] <= valid_in[n] & (open_k | bypass).
  - data_*_out update whenever valid_in[n]; otherwise hold.
  - gate_open[n] <= next state != IDLE.
  - sof_out[n] <= valid_out_next & ~last_passed, where last_passed is the per-channel flag "previous valid sample was passed".
- Effective burst span: the entry-to-HANG sample plus POST_SAMPS further samples are passed; the next sample is dropped.
- Channels with different valid patterns are independent.
- Simultaneous reset and valid: reset wins.

Test Plan:
- Default params, thresh_on=50, thresh_off=20. Ch0 gets 32 valid (0,0) samples, then (100,0) -> first valid_out one cycle after the 10th nonzero input; data_i_out=100 (burst sample 1); sof_out=1; gate_open rises at the same edge.
- Continue ch0 with (0,0) after 40 nonzero samples -> OPEN->HANG at the 14th zero; valid_out continues through the 22nd zero input, then deasserts; gate_open falls one cycle after the 23rd zero.
- In HANG (5th hang sample), return to (100,0) -> avg >50 reopens. No new sof_out, no gap in valid_out.
- GANG=1, only ch2 excited as in the first scenario, all channels valid every cycle -> valid_out=4'b1111 from the same cycle; sof_out=4'b1111 once.
- rst pulsed for 1 cycle mid-burst -> next cycle all outputs 0. Re-exciting requires 10 nonzero samples again, and the delayed data shows zeros from the cleared history (data_i_out=0 for 0 pre-trigger samples before burst sample 1).
- bypass=1, thresholds 0xFFFF, random valid -> valid_out equals valid_in delayed 1 cycle; data is delayed PRE_SAMPS valid samples; sof_out=0.

Source files
------------

// File: rtl/ad9361_multi_gate_if.sv
// Sample stream bundle: per-channel strobe plus packed I/Q buses.
// Latency: none (wires only).
// Backpressure: none; the stream is push-only, a sample exists when its valid bit is set.
//
// Ports / members:
//   valid   [NUM_CHANS]             per-channel sample strobe
//   data_i  [NUM_CHANS*DATA_WIDTH]  I samples, channel n at [n*DATA_WIDTH +: DATA_WIDTH]
//   data_q  [NUM_CHANS*DATA_WIDTH]  Q samples, same packing
// master drives the stream, slave consumes it.
interface ad9361_multi_gate_if #(
  parameter int NUM_CHANS  = 4,
  parameter int DATA_WIDTH = 12
);
  logic [NUM_CHANS-1:0]            valid;
  logic [NUM_CHANS*DATA_WIDTH-1:0] data_i;
  logic [NUM_CHANS*DATA_WIDTH-1:0] data_q;

  modport master (output valid, data_i, data_q);
  modport slave  (input  valid, data_i, data_q);
endinterface

// File: rtl/ad9361_multi_gate.sv
// N-channel IQ squelch gate with hysteresis, pre-trigger history, hang time, gang and bypass.
// Latency: 1 clk from rx.valid to tx.valid; forwarded data lags input by PRE_SAMPS valid samples.
// Backpressure: none; samples are passed or dropped, never stalled.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   bypass                 1 = every valid input sample is forwarded (gate FSMs keep running)
//   thresh_on/thresh_off   open (avg > on) / close (avg < off) thresholds
//   rx (slave)             incoming per-channel I/Q stream
//   tx (master)            gated, delayed I/Q stream
//   sof_out                per channel, marks the first forwarded sample of a gate burst
//   gate_open              per channel, 1 while the channel FSM is not IDLE
module ad9361_multi_gate #(
  parameter int NUM_CHANS  = 4,
  parameter int DATA_WIDTH = 12,
  parameter int ABS_WIDTH  = 16,
  parameter int AVG_LENGTH = 16,
  parameter int PRE_SAMPS  = 8,
  parameter int POST_SAMPS = 8,
  parameter int GANG       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bypass,
  input  logic [ABS_WIDTH-1:0] thresh_on,
  input  logic [ABS_WIDTH-1:0] thresh_off,
  ad9361_multi_gate_if.slave   rx,
  ad9361_multi_gate_if.master  tx,
  output logic [NUM_CHANS-1:0] sof_out,
  output logic [NUM_CHANS-1:0] gate_open
);

  localparam int AVG_LOG = $clog2(AVG_LENGTH);
  localparam int SUM_W   = ABS_WIDTH + AVG_LOG;
  localparam int CNT_W   = (POST_SAMPS > 0) ? $clog2(POST_SAMPS + 1) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPEN = 2'd1;
  localparam logic [1:0] ST_HANG = 2'd2;

  // Per-channel "next state is not IDLE"; combined across channels when ganged.
  logic [NUM_CHANS-1:0] own_open;
  logic [NUM_CHANS-1:0] pass_en;

  assign pass_en = (GANG != 0) ? {NUM_CHANS{|own_open}} : own_open;

  for (genvar n = 0; n < NUM_CHANS; n++) begin : g_ch
    logic                  vld;
    logic [DATA_WIDTH-1:0] smp_i, smp_q;
    logic [DATA_WIDTH:0]   ext_i, ext_q, abs_i, abs_q;
    logic [ABS_WIDTH-1:0]  mag;

    assign vld   = rx.valid[n];
    assign smp_i = rx.data_i[n*DATA_WIDTH +: DATA_WIDTH];
    assign smp_q = rx.data_q[n*DATA_WIDTH +: DATA_WIDTH];

    // One extra bit so the most negative sample's magnitude is representable.
    assign ext_i = {smp_i[DATA_WIDTH-1], smp_i};
    assign ext_q = {smp_q[DATA_WIDTH-1], smp_q};
    assign abs_i = ext_i[DATA_WIDTH] ? (~ext_i + 1'b1) : ext_i;
    assign abs_q = ext_q[DATA_WIDTH] ? (~ext_q + 1'b1) : ext_q;
    assign mag   = ABS_WIDTH'(abs_i) + ABS_WIDTH'(abs_q);

    // ---------------- boxcar average ----------------
    logic [ABS_WIDTH-1:0] hist [AVG_LENGTH];
    logic [SUM_W-1:0]     sum, sum_nxt;
    logic [ABS_WIDTH-1:0] avg;

    assign sum_nxt = sum + SUM_W'(mag) - SUM_W'(hist[AVG_LENGTH-1]);

    // avg is registered, so the decision at a sample sees only the samples before it.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < AVG_LENGTH; i++) hist[i] <= '0;
        sum <= '0;
        avg <= '0;
      end else if (vld) begin
        hist[0] <= mag;
        for (int i = 1; i < AVG_LENGTH; i++) hist[i] <= hist[i-1];
        sum <= sum_nxt;
        avg <= sum_nxt[SUM_W-1:AVG_LOG];
      end
    end

    // ---------------- gate FSM ----------------
    logic [1:0]       state, nstate;
    logic [CNT_W-1:0] cnt, ncnt;

    always_comb begin
      nstate = state;
      ncnt   = cnt;
      if (vld) begin
        case (state)
          ST_IDLE: if (avg > thresh_on) nstate = ST_OPEN;
          ST_OPEN: begin
            if (avg < thresh_off) begin
              nstate = ST_HANG;
              ncnt   = CNT_W'(POST_SAMPS);
            end
          end
          ST_HANG: begin
            if (avg > thresh_on) nstate = ST_OPEN;
            else if (cnt != '0)  ncnt   = cnt - 1'b1;
            else                 nstate = ST_IDLE;
          end
          default: nstate = ST_IDLE;
        endcase
      end
    end

    assign own_open[n] = (nstate != ST_IDLE);

    // ---------------- pre-trigger delay ----------------
    logic [DATA_WIDTH-1:0] tap_i, tap_q;

    if (PRE_SAMPS > 0) begin : g_dly
      logic [DATA_WIDTH-1:0] dl_i [PRE_SAMPS];
      logic [DATA_WIDTH-1:0] dl_q [PRE_SAMPS];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PRE_SAMPS; i++) begin
            dl_i[i] <= '0;
            dl_q[i] <= '0;
          end
        end else if (vld) begin
          dl_i[0] <= smp_i;
          dl_q[0] <= smp_q;
          for (int i = 1; i < PRE_SAMPS; i++) begin
            dl_i[i] <= dl_i[i-1];
            dl_q[i] <= dl_q[i-1];
          end
        end
      end

      assign tap_i = dl_i[PRE_SAMPS-1];
      assign tap_q = dl_q[PRE_SAMPS-1];
    end else begin : g_nodly
      assign tap_i = smp_i;
      assign tap_q = smp_q;
    end

    // ---------------- registered outputs ----------------
    logic                  vo_q, sof_q, go_q, last_passed;
    logic [DATA_WIDTH-1:0] do_i, do_q;

    // last_passed / sof follow the gate, not bypass: a bypassed stream is not a
    // burst, so it never produces start-of-burst markers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state       <= ST_IDLE;
        cnt         <= '0;
        vo_q        <= 1'b0;
        sof_q       <= 1'b0;
        go_q        <= 1'b0;
        last_passed <= 1'b0;
        do_i        <= '0;
        do_q        <= '0;
      end else begin
        state <= nstate;
        cnt   <= ncnt;
        go_q  <= (nstate != ST_IDLE);
        vo_q  <= vld & (pass_en[n] | bypass);
        sof_q <= vld & pass_en[n] & ~last_passed;
        if (vld) begin
          last_passed <= pass_en[n];
          do_i        <= tap_i;
          do_q        <= tap_q;
        end
      end
    end

    assign tx.valid[n]                          = vo_q;
    assign tx.data_i[n*DATA_WIDTH +: DATA_WIDTH] = do_i;
    assign tx.data_q[n*DATA_WIDTH +: DATA_WIDTH] = do_q;
    assign sof_out[n]                           = sof_q;
    assign gate_open[n]                         = go_q;
  end

endmodule

// File: tb/tb_ad9361_multi_gate.sv
// Directed bench for ad9361_multi_gate: one ungated-gang instance (A) and one GANG=1 instance (B).
// Outputs are sampled 1 time unit after the rising edge that registered the sample just driven.
// No backpressure exists; every step is one clock.
module tb_ad9361_multi_gate;

  logic        clk = 1'b0;
  logic        rst;
  logic        bypass;
  logic [15:0] thr_on, thr_off;
  logic [3:0]  sof_a, go_a, sof_b, go_b;

  int compared   = 0;
  int mismatched = 0;

  ad9361_multi_gate_if #(.NUM_CHANS(4), .DATA_WIDTH(12)) rx_a ();
  ad9361_multi_gate_if #(.NUM_CHANS(4), .DATA_WIDTH(12)) tx_a ();
  ad9361_multi_gate_if #(.NUM_CHANS(4), .DATA_WIDTH(12)) rx_b ();
  ad9361_multi_gate_if #(.NUM_CHANS(4), .DATA_WIDTH(12)) tx_b ();

  ad9361_multi_gate #(.GANG(0)) dut_a (
    .clk(clk), .rst(rst), .bypass(bypass), .thresh_on(thr_on), .thresh_off(thr_off),
    .rx(rx_a), .tx(tx_a), .sof_out(sof_a), .gate_open(go_a)
  );

  ad9361_multi_gate #(.GANG(1)) dut_b (
    .clk(clk), .rst(rst), .bypass(1'b0), .thresh_on(thr_on), .thresh_off(thr_off),
    .rx(rx_b), .tx(tx_b), .sof_out(sof_b), .gate_open(go_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel valid patterns for the bypass run.
  logic [3:0] vtab [0:23] = '{4'b0001, 4'b0011, 4'b0000, 4'b1001, 4'b0101, 4'b0001, 4'b1110, 4'b0001,
                              4'b0000, 4'b0001, 4'b0111, 4'b0001, 4'b1000, 4'b0001, 4'b0001, 4'b0010,
                              4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0001, 4'b1011};

  initial begin
    int s;
    logic [11:0] exp_d;

    rst = 1'b1; bypass = 1'b0; thr_on = 16'd50; thr_off = 16'd20;
    rx_a.valid = '0; rx_a.data_i = '0; rx_a.data_q = '0;
    rx_b.valid = '0; rx_b.data_i = '0; rx_b.data_q = '0;
    repeat (3) tick();

    chk("rst_vld_a", tx_a.valid, 0);
    chk("rst_sof_a", sof_a, 0);
    chk("rst_go_a", go_a, 0);
    chk("rst_di_a", tx_a.data_i, 0);
    chk("rst_vld_b", tx_b.valid, 0);
    rst = 1'b0;

    // Scenario 1: quiet lead-in, 40-sample burst of (100,0) on ch0, then silence.
    rx_a.valid = 4'b0001;
    repeat (32) tick();
    chk("s1_quiet_vld", tx_a.valid, 0);
    chk("s1_quiet_go", go_a, 0);

    rx_a.data_i[11:0] = 12'd100;
    for (int j = 1; j <= 40; j++) begin
      tick();
      chk($sformatf("s1_on%0d_vld", j), tx_a.valid, {3'b000, (j >= 10)});
      chk($sformatf("s1_on%0d_sof", j), sof_a, {3'b000, (j == 10)});
      chk($sformatf("s1_on%0d_go", j), go_a, {3'b000, (j >= 10)});
      chk($sformatf("s1_on%0d_di", j), tx_a.data_i[11:0], (j >= 9) ? 12'd100 : 12'd0);
    end

    rx_a.data_i[11:0] = 12'd0;
    for (int z = 1; z <= 25; z++) begin
      tick();
      chk($sformatf("s1_off%0d_vld", z), tx_a.valid, {3'b000, (z <= 22)});
      chk($sformatf("s1_off%0d_sof", z), sof_a, 0);
      chk($sformatf("s1_off%0d_go", z), go_a, {3'b000, (z <= 22)});
      chk($sformatf("s1_off%0d_di", z), tx_a.data_i[11:0], (z <= 8) ? 12'd100 : 12'd0);
    end

    // Scenario 2: reopen from HANG (hang entered at 14th zero) with a strong signal.
    rx_a.data_i[11:0] = 12'd100;
    for (int j = 1; j <= 40; j++) begin
      tick();
      chk($sformatf("s2_on%0d_vld", j), tx_a.valid, {3'b000, (j >= 10)});
      chk($sformatf("s2_on%0d_sof", j), sof_a, {3'b000, (j == 10)});
    end
    rx_a.data_i[11:0] = 12'd0;
    for (int z = 1; z <= 18; z++) begin
      tick();
      chk($sformatf("s2_off%0d_vld", z), tx_a.valid, 4'b0001);
      chk($sformatf("s2_off%0d_sof", z), sof_a, 0);
    end
    rx_a.data_i[11:0] = 12'h7FF;
    rx_a.data_q[11:0] = 12'h7FF;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("s2_re%0d_vld", k), tx_a.valid, 4'b0001);
      chk($sformatf("s2_re%0d_sof", k), sof_a, 0);
      chk($sformatf("s2_re%0d_go", k), go_a, 4'b0001);
    end

    // Scenario 3: reset mid-burst (coincident valid), then re-excite.
    rst = 1'b1;
    rx_a.data_i[11:0] = 12'd100;
    rx_a.data_q[11:0] = 12'd0;
    tick();
    chk("s3_rst_vld", tx_a.valid, 0);
    chk("s3_rst_sof", sof_a, 0);
    chk("s3_rst_go", go_a, 0);
    chk("s3_rst_di", tx_a.data_i, 0);
    chk("s3_rst_dq", tx_a.data_q, 0);
    rst = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk($sformatf("s3_on%0d_vld", j), tx_a.valid, {3'b000, (j >= 10)});
      chk($sformatf("s3_on%0d_sof", j), sof_a, {3'b000, (j == 10)});
      if (j == 8)  chk("s3_cleared_di", tx_a.data_i[11:0], 12'd0);
      if (j == 10) chk("s3_first_di", tx_a.data_i[11:0], 12'd100);
    end

    // Scenario 4: ganged instance, only ch2 carries signal.
    rx_a.valid = '0;
    rx_b.valid = 4'b1111;
    rx_b.data_i[35:24] = 12'd100;
    for (int j = 1; j <= 11; j++) begin
      tick();
      chk($sformatf("gang%0d_vld", j), tx_b.valid, (j >= 10) ? 4'b1111 : 4'b0000);
      chk($sformatf("gang%0d_sof", j), sof_b, (j == 10) ? 4'b1111 : 4'b0000);
      chk($sformatf("gang%0d_go", j), go_b, (j >= 10) ? 4'b0100 : 4'b0000);
    end

    // Scenario 5: bypass with unreachable thresholds; ch0 carries a sample counter.
    rx_b.valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bypass = 1'b1; thr_on = 16'hFFFF; thr_off = 16'hFFFF;
    rx_a.data_i = '0; rx_a.data_q = '0;
    s = 0; exp_d = 12'd0;
    for (int k = 0; k < 24; k++) begin
      rx_a.valid = vtab[k];
      if (vtab[k][0]) begin
        s++;
        rx_a.data_i[11:0] = 12'(s);
      end
      tick();
      if (vtab[k][0]) exp_d = (s > 8) ? 12'(s - 8) : 12'd0;
      chk($sformatf("byp%0d_vld", k), tx_a.valid, vtab[k]);
      chk($sformatf("byp%0d_sof", k), sof_a, 0);
      chk($sformatf("byp%0d_di", k), tx_a.data_i[11:0], exp_d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
